// File: rtl/shift_packer_pkg.sv
// Shared helpers for the beat packer: lane bit offsets
// and fill counter width.
package shift_packer_pkg;

  function automatic int fill_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int lane_off(
    input int lane,
    input int dw,
    input int lanes,
    input bit msb_first
  );
    return msb_first ? (lanes - lane - 1) * dw
                     : lane * dw;
  endfunction

endpackage

// File: rtl/shift_packer_if.sv
// Beat-in / word-out handshake bundle of shift_packer.
// slave: packer side; master: producer/consumer side.
interface shift_packer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  import shift_packer_pkg::*;

  localparam int FW = fill_w(LANES);

  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    ready_in;
  logic                    flush_in;
  logic [DATA_W*LANES-1:0] data_out;
  logic [LANES-1:0]        keep_out;
  logic                    valid_out;
  logic                    ready_out;
  logic [FW-1:0]           fill_level;

  modport slave (
    input  data_in, valid_in, flush_in, ready_out,
    output ready_in, data_out, keep_out, valid_out,
    output fill_level
  );

  modport master (
    output data_in, valid_in, flush_in, ready_out,
    input  ready_in, data_out, keep_out, valid_out,
    input  fill_level
  );

endinterface

// File: rtl/shift_packer_slot.sv
// Output word register: load/hold/drain of data, keep, valid.
// Ports: load+word in, ready_out in, registered word out, slot_free.
module shift_packer_slot #(
  parameter int W     = 32,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic [LANES-1:0] load_keep,
  input  logic             ready_out,
  output logic [W-1:0]     data_out,
  output logic [LANES-1:0] keep_out,
  output logic             valid_out,
  output logic             slot_free
);

  assign slot_free = !valid_out || ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      keep_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= load_data;
      keep_out  <= load_keep;
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_packer.sv
// Packs LANES beats of DATA_W bits into one word, with flush.
// Ports: clk, rst_n, bus (shift_packer_if.slave).
module shift_packer
  import shift_packer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  shift_packer_if.slave bus
);

  localparam int W  = DATA_W * LANES;
  localparam int FW = fill_w(LANES);

  logic [W-1:0]     asm_q;
  logic [W-1:0]     asm_w;
  logic [LANES-1:0] keep_w;
  logic [FW-1:0]    fill;
  logic             slot_free;
  logic             accept;
  logic             full;
  logic             do_flush;
  logic             load;

  assign bus.ready_in = slot_free ||
    (int'(fill) < LANES - 1 && !bus.flush_in);
  assign accept   = bus.valid_in && bus.ready_in;
  assign full     = accept && int'(fill) == LANES - 1;
  assign do_flush = bus.flush_in && slot_free &&
    (fill != '0 || accept);
  assign load     = full || do_flush;
  assign bus.fill_level = fill;

  // Word as it stands including this cycle's beat.
  always_comb begin
    asm_w  = asm_q;
    keep_w = '0;
    for (int i = 0; i < LANES; i++) begin
      if (accept && int'(fill) == i)
        asm_w[lane_off(i, DATA_W, LANES, MSB_FIRST) +: DATA_W]
          = bus.data_in;
      keep_w[i] = (i < int'(fill)) ||
        (accept && int'(fill) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      fill  <= '0;
    end else if (load) begin
      asm_q <= '0;
      fill  <= '0;
    end else if (accept) begin
      asm_q <= asm_w;
      fill  <= fill + FW'(1);
    end
  end

  shift_packer_slot #(
    .W     (W),
    .LANES (LANES)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (asm_w),
    .load_keep (keep_w),
    .ready_out (bus.ready_out),
    .data_out  (bus.data_out),
    .keep_out  (bus.keep_out),
    .valid_out (bus.valid_out),
    .slot_free (slot_free)
  );

endmodule
